// File: rtl/temp_pkg.sv
// Shared definitions for the temperature comparison datapath: flag bit
// positions, temperature field type, warm-up FSM states and filter width.
package temp_pkg;

  localparam int FLG_HEAT  = 0;
  localparam int FLG_COOL  = 1;
  localparam int FLG_HDONE = 2;
  localparam int FLG_CDONE = 3;

  localparam int CNT_W = 4;

  typedef logic [6:0] temp_t;

  typedef enum logic {WARMUP, RUN} state_t;

endpackage

// File: rtl/flag_filter.sv
// Persistence filter for one comparison flag: a saturating run-length
// counter plus the qualified output register.
module flag_filter
  import temp_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic upd,
  input  logic raw,
  output logic flag
);

  localparam logic [CNT_W-1:0] LEN     = CNT_W'(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt_p1;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = sat_inc(cnt_p1);

  // filter stage: the update that reaches LEN also asserts the flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p1 <= '0;
      flag   <= 1'b0;
    end else if (upd) begin
      if (raw) begin
        cnt_p1 <= cnt_inc;
        flag   <= (cnt_inc >= LEN);
      end else begin
        cnt_p1 <= '0;
        flag   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/temp_datapath.sv
// Temperature comparison datapath: capture, bound compare, per-flag
// persistence filter and warm-up FSM. Optional troom averaging: TEMP_DP_AVG_EN.
module temp_datapath
  import temp_pkg::*;
#(
  parameter int FILTER_LEN = 3,
  parameter int TW         = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_en,
  input  logic [TW-1:0] datapath_in1,
  input  logic [TW-1:0] datapath_in2,
  input  logic [TW-1:0] datapath_in3,
  output logic [3:0]    datapath_out,
  output logic          valid
);

`ifdef TEMP_DP_AVG_EN
  localparam int WARM_LEN = (FILTER_LEN > 4) ? FILTER_LEN : 4;
`else
  localparam int WARM_LEN = FILTER_LEN;
`endif
  localparam logic [CNT_W-1:0] WARM_CNT = CNT_W'(WARM_LEN);

  logic [TW-1:0] tref_p0;
  logic [TW-1:0] dt_p0;
  logic [TW-1:0] troom_eff;
  logic          smp_d;

`ifdef TEMP_DP_AVG_EN
  logic [TW-1:0] hist_p0 [4];

  function automatic logic [TW-1:0] avg4(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                         input logic [TW-1:0] c, input logic [TW-1:0] d);
    logic [TW+1:0] s;
    s = (TW+2)'(a) + (TW+2)'(b) + (TW+2)'(c) + (TW+2)'(d);
    return TW'(s >> 2);
  endfunction
`else
  logic [TW-1:0] troom_p0;
`endif

  // stage 1: capture on strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smp_d   <= 1'b0;
      tref_p0 <= '0;
      dt_p0   <= '0;
`ifdef TEMP_DP_AVG_EN
      for (int i = 0; i < 4; i++) hist_p0[i] <= '0;
`else
      troom_p0 <= '0;
`endif
    end else begin
      smp_d <= sample_en;
      if (sample_en) begin
        tref_p0 <= datapath_in2;
        dt_p0   <= datapath_in3;
`ifdef TEMP_DP_AVG_EN
        hist_p0[0] <= datapath_in1;
        for (int i = 1; i < 4; i++) hist_p0[i] <= hist_p0[i-1];
`else
        troom_p0 <= datapath_in1;
`endif
      end
    end
  end

`ifdef TEMP_DP_AVG_EN
  assign troom_eff = avg4(hist_p0[0], hist_p0[1], hist_p0[2], hist_p0[3]);
`else
  assign troom_eff = troom_p0;
`endif

  // stage 2: widened bounds so neither side can wrap
  logic        [TW:0]   upper;
  logic signed [TW+1:0] lower;
  logic        [3:0]    raw;
  logic        [3:0]    flags;

  assign upper = {1'b0, tref_p0} + {1'b0, dt_p0};
  assign lower = $signed({2'b00, tref_p0}) - $signed({2'b00, dt_p0});

  assign raw[FLG_HEAT]  = $signed({2'b00, troom_eff}) < lower;
  assign raw[FLG_COOL]  = {1'b0, troom_eff} > upper;
  assign raw[FLG_HDONE] = troom_eff >= tref_p0;
  assign raw[FLG_CDONE] = troom_eff <= tref_p0;

  for (genvar g = 0; g < 4; g++) begin : g_filt
    flag_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
      .clk   (clk),
      .reset (reset),
      .upd   (smp_d),
      .raw   (raw[g]),
      .flag  (flags[g])
    );
  end

  state_t           state;
  logic [CNT_W-1:0] wcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WARMUP;
      wcnt  <= '0;
      valid <= 1'b0;
    end else begin
      case (state)
        WARMUP: if (smp_d) begin
          wcnt <= wcnt + CNT_W'(1);
          if (wcnt + CNT_W'(1) == WARM_CNT) begin
            state <= RUN;
            valid <= 1'b1;
          end
        end
        RUN: valid <= 1'b1;
      endcase
    end
  end

  assign datapath_out = valid ? flags : 4'b0000;

endmodule

// File: doc/temp_datapath.md
# temp_datapath

Comparison datapath that pairs with the temperature-controller FSM. It takes the room temperature, reference temperature and tolerance band that the controller drives out, and returns the 4-bit flag word the controller branches on: heat, cool, heat-done and cool-done. Samples are taken on a strobe, and each flag is qualified by a persistence filter so sensor noise cannot chatter the heater or cooler. A warm-up FSM holds all flags low until the filter has seen enough samples.

## Interface
- `FILTER_LEN`, default 3: consecutive qualifying samples required before a flag asserts. Legal range is 1..15.
- `TW`, default 7: temperature field width.

Ports:
- `clk`  in  1  system clock; all registers update on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears every register.
- `sample_en`  in  1  single-cycle strobe; capture the inputs this cycle.
- `datapath_in1`  in  TW  troom, unsigned.
- `datapath_in2`  in  TW  tref, unsigned.
- `datapath_in3`  in  TW  dt, unsigned tolerance.
- `datapath_out`  out  4  qualified flags:
  - [0] heat: troom < tref − dt
  - [1] cool: troom > tref + dt
  - [2] heat-done: troom ≥ tref
  - [3] cool-done: troom ≤ tref
- `valid`  out  1  high once warm-up is complete.

## Operation
- **Stage 1 (capture):** on a `clk` edge with `sample_en`=1, the three inputs are registered, and a delayed strobe `smp_d` is set for one cycle.
- **Stage 2 (compare):** raw flags are computed combinationally from the stage-1 registers.
- **Arithmetic:**
  - The upper bound `tref+dt` is computed in TW+1 bits, unsigned.
  - The lower bound `tref−dt` is computed in TW+2 bits, signed.
  - troom is zero-extended to match each bound.
  - No wrap is permitted. If `tref−dt` is negative, flag [0] is 0. If `tref+dt` is above 127, flag [1] is 0 unless troom exceeds it.
- **Filter:** each flag has a saturating 4-bit counter, updated only on `smp_d`.
  - Raw flag 1: the counter increments, saturating at 15.
  - Raw flag 0: the counter clears.
  - The output bit is registered high when counter ≥ `FILTER_LEN`, including the update that reaches it.
  - Release is immediate: the first non-qualifying sample clears the bit at that same update.
- **FSM:**
  - States are WARMUP (the reset state) and RUN.
  - A sample counter increments on each `smp_d` while in WARMUP.
  - WARMUP→RUN on the `smp_d` update that makes the count reach `WARM_LEN`. `WARM_LEN` = `FILTER_LEN`, or max(`FILTER_LEN`, 4) when averaging is compiled in.
  - RUN has no exit except `reset`.
  - `valid` = (state==RUN).
  - `datapath_out` is masked to 0 while in WARMUP. The filter counters still run during WARMUP.
- **Flag combinations:**
  - [0] and [1] are mutually exclusive by construction.
  - [2] and [3] are both 1 when troom==tref.
- **Input changes:** a change of tref or dt between samples takes effect at the next capture only.

## Timing
- **Reset values:** `datapath_out`=0, `valid`=0, all counters 0, state WARMUP, `smp_d`=0. Assertion takes effect immediately (asynchronous), including mid-run. After deassertion, operation resumes from WARMUP.
- **Latency:** capture at edge t, filter/output update at edge t+1.
- **Assertion time:** a flag asserts at edge t+1 of the `FILTER_LEN`-th consecutive qualifying capture. It deasserts at edge t+1 of the first non-qualifying capture.
- **Strobe spacing:** back-to-back `sample_en` (every cycle) is legal and yields one update per cycle.
- **Strobe during reset:** `sample_en` while `reset`=1 is ignored.

## Configuration
- `TEMP_DP_AVG_EN` defined:
  - troom passes through a 4-entry shift register, filled on capture.
  - The compare uses (sum of 4) >> 2, with a 9-bit sum and truncating division.
  - Entries reset to 0, and warm-up is extended as above so the average is fully populated before `valid`.
- Undefined: the raw captured troom is compared directly.

## Structure
- **Shared package `temp_pkg`:**
  - flag bit indices FLG_HEAT=0, FLG_COOL=1, FLG_HDONE=2, FLG_CDONE=3
  - `temp_t` (7-bit)
  - FSM state enum {WARMUP, RUN}
  - filter counter width 4
- **Sub-module `flag_filter`:** one instance per flag, containing the persistence counter and output register, with `FILTER_LEN` as a parameter.

## Test plan
- **Heat request:** reset, then troom=20, tref=30, dt=5, `sample_en` every 4 cycles, `FILTER_LEN`=3. Required: `valid`=0 and out=0 through the 2nd sample; `valid`=1 and out=4'b1001 at the edge after the 3rd capture.
- **Cool request:** troom=40, tref=30, dt=5, after warm-up. Required: out=4'b0110 after 3 consecutive samples.
- **Equality case:** troom=tref=30, dt=0. Required: out=4'b1100.
- **Glitch rejection:** heat-qualifying, heat-qualifying, then troom=30, then 3 qualifying samples. Required: bit0 stays 0 through the glitch and asserts only after the 3rd post-glitch sample. A single non-qualifying sample later clears it at the next update.
- **No-wrap bounds:**
  - tref=120, dt=10, troom=127: bit1=0.
  - tref=5, dt=10, troom=0: bit0=0, bit3=1.
- **Mid-run reset:** `reset` pulsed asynchronously mid-cycle while out≠0. Required: out=0 and `valid`=0 immediately; `FILTER_LEN` samples are needed again before `valid`. With `TEMP_DP_AVG_EN`, `valid` needs 4 samples, and the average of 20,20,20,24 gives 21.
